// File: rtl/tank_bullet.sv
// Single tank bullet: launches from the tank centre on a frame tick, flies one
// STEP per frame in the latched direction, then blocks relaunch for COOLDOWN frames.
module tank_bullet #(
    parameter int STEP     = 4,
    parameter int SIZE     = 4,
    parameter int COOLDOWN = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       is_shooting,
    input  logic [2:0] tank_dir,
    input  logic [9:0] tank_X,
    input  logic [9:0] tank_Y,
    output logic       is_bullet,
    output logic       bullet_active,
    output logic [9:0] bullet_X,
    output logic [9:0] bullet_Y,
    output logic [2:0] bullet_dir
);

    localparam int CW = ($clog2(COOLDOWN + 1) < 1) ? 1 : $clog2(COOLDOWN + 1);

    localparam logic [10:0] X_LIMIT = 11'(640 - SIZE);
    localparam logic [10:0] Y_LIMIT = 11'(480 - SIZE);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] SIZE11  = 11'(SIZE);
    localparam logic [10:0] CENTER  = 11'd14;

    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLYING,
        S_COOLDOWN
    } state_t;

    state_t          state, state_next;
    logic            frame_clk_d;
    logic            frame_tick;
    logic            fire_req, fire_req_next;
    logic            fire;
    logic            terminate;
    logic            dir_valid;
    logic            spawn_ok;
    logic [CW-1:0]   cooldown, cooldown_next;
    logic            active_next;
    logic [9:0]      x_next, y_next;
    logic [2:0]      dir_next;
    logic [10:0]     spawn_x, spawn_y;
    logic [10:0]     bx, by;
    logic [10:0]     dx, dy;

    assign bx      = {1'b0, bullet_X};
    assign by      = {1'b0, bullet_Y};
    assign spawn_x = {1'b0, tank_X} + CENTER;
    assign spawn_y = {1'b0, tank_Y} + CENTER;

    assign dir_valid = (tank_dir == DIR_UP) || (tank_dir == DIR_RIGHT) ||
                       (tank_dir == DIR_LEFT) || (tank_dir == DIR_DOWN);
    assign spawn_ok  = (spawn_x <= X_LIMIT) && (spawn_y <= Y_LIMIT);

    // A shot pulse landing on the tick cycle itself still counts.
    assign fire = frame_tick & (fire_req | is_shooting);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= S_IDLE;
            frame_clk_d   <= 1'b0;
            frame_tick    <= 1'b0;
            fire_req      <= 1'b0;
            cooldown      <= '0;
            bullet_active <= 1'b0;
            bullet_X      <= '0;
            bullet_Y      <= '0;
            bullet_dir    <= '0;
        end else begin
            state         <= state_next;
            frame_clk_d   <= frame_clk;
            frame_tick    <= frame_clk & ~frame_clk_d;
            fire_req      <= fire_req_next;
            cooldown      <= cooldown_next;
            bullet_active <= active_next;
            bullet_X      <= x_next;
            bullet_Y      <= y_next;
            bullet_dir    <= dir_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        fire_req_next = frame_tick ? 1'b0 : (fire_req | is_shooting);
        cooldown_next = cooldown;
        active_next   = bullet_active;
        x_next        = bullet_X;
        y_next        = bullet_Y;
        dir_next      = bullet_dir;
        terminate     = 1'b0;

        if (frame_tick) begin
            unique case (state)
                S_IDLE: begin
                    if (fire && dir_valid && spawn_ok) begin
                        state_next  = S_FLYING;
                        active_next = 1'b1;
                        x_next      = spawn_x[9:0];
                        y_next      = spawn_y[9:0];
                        dir_next    = tank_dir;
                    end
                end

                S_FLYING: begin
                    case (bullet_dir)
                        DIR_UP: begin
                            if (by < STEP11) terminate = 1'b1;
                            else             y_next = 10'(by - STEP11);
                        end
                        DIR_DOWN: begin
                            if (by + STEP11 > Y_LIMIT) terminate = 1'b1;
                            else                       y_next = 10'(by + STEP11);
                        end
                        DIR_RIGHT: begin
                            if (bx + STEP11 > X_LIMIT) terminate = 1'b1;
                            else                       x_next = 10'(bx + STEP11);
                        end
                        DIR_LEFT: begin
                            if (bx < STEP11) terminate = 1'b1;
                            else             x_next = 10'(bx - STEP11);
                        end
                        default: terminate = 1'b1;
                    endcase

                    // Position and direction stay frozen at their last values.
                    if (terminate) begin
                        state_next    = S_COOLDOWN;
                        active_next   = 1'b0;
                        cooldown_next = CW'(COOLDOWN);
                    end
                end

                S_COOLDOWN: begin
                    if (cooldown <= CW'(1)) begin
                        state_next    = S_IDLE;
                        cooldown_next = '0;
                    end else begin
                        cooldown_next = cooldown - CW'(1);
                    end
                end

                default: state_next = S_IDLE;
            endcase
        end
    end

    assign dx = {1'b0, DrawX};
    assign dy = {1'b0, DrawY};

    assign is_bullet = bullet_active &&
                       (dx >= bx) && (dx <= bx + SIZE11 - 11'd1) &&
                       (dy >= by) && (dy <= by + SIZE11 - 11'd1);

endmodule

// File: tb/tb_tank_bullet.sv
// Bench for tank_bullet: directed scenarios then random fire/tank activity,
// all compared against a frame-level behavioural model.
module tb_tank_bullet;

    localparam int STEP     = 4;
    localparam int SIZE     = 4;
    localparam int COOLDOWN = 16;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [9:0] DrawX, DrawY;
    logic       is_shooting;
    logic [2:0] tank_dir;
    logic [9:0] tank_X, tank_Y;
    logic       is_bullet;
    logic       bullet_active;
    logic [9:0] bullet_X, bullet_Y;
    logic [2:0] bullet_dir;

    tank_bullet #(.STEP(STEP), .SIZE(SIZE), .COOLDOWN(COOLDOWN)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .is_shooting  (is_shooting),
        .tank_dir     (tank_dir),
        .tank_X       (tank_X),
        .tank_Y       (tank_Y),
        .is_bullet    (is_bullet),
        .bullet_active(bullet_active),
        .bullet_X     (bullet_X),
        .bullet_Y     (bullet_Y),
        .bullet_dir   (bullet_dir)
    );

    always #10 Clk = ~Clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Frame-level model: bullet state plus frames of cooldown still to wait.
    int m_active, m_x, m_y, m_dir, m_cool;
    bit pending;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 0; m_x = 0; m_y = 0; m_dir = 0; m_cool = 0;
        pending  = 1'b0;
    endfunction

    function automatic void model_tick(input bit fire);
        int nx, ny;
        bit stop;
        if (m_active != 0) begin
            nx = m_x; ny = m_y; stop = 1'b0;
            case (m_dir)
                1: begin ny = m_y - STEP; stop = (ny < 0); end
                4: begin ny = m_y + STEP; stop = (ny > 480 - SIZE); end
                2: begin nx = m_x + STEP; stop = (nx > 640 - SIZE); end
                3: begin nx = m_x - STEP; stop = (nx < 0); end
                default: stop = 1'b1;
            endcase
            if (stop) begin
                m_active = 0;
                m_cool   = COOLDOWN;
            end else begin
                m_x = nx; m_y = ny;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (fire && tank_dir >= 1 && tank_dir <= 4 &&
                     int'(tank_X) + 14 <= 640 - SIZE && int'(tank_Y) + 14 <= 480 - SIZE) begin
            m_active = 1;
            m_x      = int'(tank_X) + 14;
            m_y      = int'(tank_Y) + 14;
            m_dir    = int'(tank_dir);
        end
    endfunction

    task automatic cyc(input bit shoot);
        @(negedge Clk);
        is_shooting = shoot;
        @(posedge Clk);
        if (shoot) pending = 1'b1;
    endtask

    // One frame: frame_clk rises, the DUT sees the tick one edge later.
    task automatic do_tick(input bit shoot_on_tick);
        @(negedge Clk);
        frame_clk   = 1'b1;
        is_shooting = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        is_shooting = shoot_on_tick;
        @(posedge Clk);
        model_tick(pending | shoot_on_tick);
        pending = 1'b0;
        @(negedge Clk);
        is_shooting = 1'b0;
        frame_clk   = 1'b0;
        @(posedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset       = 1'b1;
        is_shooting = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic pix(input string tag, input int px, input int py, input bit exp);
        @(negedge Clk);
        DrawX = 10'(px);
        DrawY = 10'(py);
        #1;
        check(tag, is_bullet, exp);
    endtask

    task automatic check_all(input string tag);
        int dx, dy;
        bit exp_pix;
        @(negedge Clk);
        dx = m_x - 2 + int'($urandom_range(0, SIZE + 3));
        dy = m_y - 2 + int'($urandom_range(0, SIZE + 3));
        if (dx < 0) dx = 0;
        if (dy < 0) dy = 0;
        if (dx > 1023) dx = 1023;
        if (dy > 1023) dy = 1023;
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        #1;
        exp_pix = (m_active != 0) && dx >= m_x && dx < m_x + SIZE && dy >= m_y && dy < m_y + SIZE;
        check({tag, ".active"}, bullet_active, m_active);
        check({tag, ".x"}, bullet_X, m_x);
        check({tag, ".y"}, bullet_Y, m_y);
        check({tag, ".dir"}, bullet_dir, m_dir);
        check({tag, ".pix"}, is_bullet, exp_pix);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; is_shooting = 1'b0;
        DrawX = '0; DrawY = '0; tank_dir = '0; tank_X = '0; tank_Y = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        check_all("reset");
        @(negedge Clk);
        Reset = 1'b0;

        // Launch upward from (500,240), then three frames of travel.
        tank_X = 10'd500; tank_Y = 10'd240; tank_dir = 3'd1;
        cyc(1'b1); cyc(1'b0);
        do_tick(1'b0);
        check_all("launch");
        check("launch_xy", {bullet_X, bullet_Y}, {10'd514, 10'd254});
        pix("pix_in", 517, 257, 1'b1);
        pix("pix_out", 518, 257, 1'b0);
        repeat (3) do_tick(1'b0);
        check_all("fly_up");
        check("fly_up_y", bullet_Y, 242);

        // Leftward bullet hits the edge; relaunch only on the 17th frame after.
        do_reset();
        tank_X = 10'd0; tank_Y = 10'd100; tank_dir = 3'd3;
        cyc(1'b1);
        do_tick(1'b0);
        repeat (2) do_tick(1'b0);
        check("left_x6", bullet_X, 6);
        do_tick(1'b0);
        check("left_x2", bullet_X, 2);
        do_tick(1'b0);
        check_all("left_end");
        check("left_end_x", bullet_X, 2);
        for (int i = 1; i <= 17; i++) begin
            do_tick(1'b1);
            @(negedge Clk);
            check($sformatf("cool_%0d", i), bullet_active, (i == 17));
        end
        check_all("relaunch");

        // Spawn off the right edge is dropped.
        do_reset();
        tank_X = 10'd630; tank_Y = 10'd100; tank_dir = 3'd2;
        cyc(1'b1);
        do_tick(1'b0);
        check_all("spawn_oob");

        // Constant firing and tank motion while flying change nothing.
        do_reset();
        tank_X = 10'd300; tank_Y = 10'd200; tank_dir = 3'd2;
        cyc(1'b1);
        do_tick(1'b1);
        for (int i = 0; i < 5; i++) begin
            tank_X   = 10'(100 + 37 * i);
            tank_Y   = 10'(50 + 11 * i);
            tank_dir = 3'(1 + (i % 4));
            repeat (3) cyc(1'b1);
            do_tick(1'b1);
            check_all($sformatf("hold_fire_%0d", i));
        end

        // Reset mid-flight wins over a coincident tick and fire.
        do_reset();
        tank_X = 10'd500; tank_Y = 10'd86; tank_dir = 3'd1;
        cyc(1'b1);
        do_tick(1'b0);
        check("mid_y", bullet_Y, 100);
        @(negedge Clk);
        Reset = 1'b1; is_shooting = 1'b1; frame_clk = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0; is_shooting = 1'b0; frame_clk = 1'b0;
        model_reset();
        check_all("mid_reset");
        pix("mid_reset_pix", 514, 100, 1'b0);
        cyc(1'b1);
        do_tick(1'b0);
        check_all("after_reset");

        // Invalid directions are dropped.
        do_reset();
        tank_X = 10'd200; tank_Y = 10'd200; tank_dir = 3'd5;
        cyc(1'b1);
        do_tick(1'b0);
        check_all("dir5");
        tank_dir = 3'd0;
        cyc(1'b1);
        do_tick(1'b0);
        check_all("dir0");

        // Random play.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                tank_X   = 10'($urandom_range(0, 639));
                tank_Y   = 10'($urandom_range(0, 479));
                tank_dir = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 59) == 0) do_reset();
            repeat ($urandom_range(0, 3)) cyc($urandom_range(0, 3) == 0);
            do_tick($urandom_range(0, 7) == 0);
            check_all($sformatf("rand_%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tank_bullet.md
TANK_BULLET -- requirements
Module: tank_bullet

Interface
REQ-001 SHALL have parameter STEP, default 4, bullet pixels moved per frame tick.
REQ-002 SHALL have parameter SIZE, default 4, bullet square edge in pixels.
REQ-003 SHALL have parameter COOLDOWN, default 16, frame ticks after a bullet ends before a new one is accepted.
REQ-004 SHALL have port Clk  input  1  50 MHz system clock; the block's only clock.
REQ-005 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port frame_clk  input  1  ~60 Hz frame clock, sampled as data on Clk.
REQ-007 SHALL have port DrawX, DrawY  input  10 each  current VGA pixel coordinates.
REQ-008 SHALL have port is_shooting  input  1  fire request from the tank controller, may be a 1-cycle pulse.
REQ-009 SHALL have port tank_dir  input  3  tank facing: 1 up, 2 right, 3 left, 4 down; other values invalid.
REQ-010 SHALL have port tank_X, tank_Y  input  10 each  tank top-left corner; tank is 32x32.
REQ-011 SHALL have port is_bullet  output  1  current pixel belongs to the live bullet.
REQ-012 SHALL have port bullet_active  output  1  a bullet is in flight.
REQ-013 SHALL have port bullet_X, bullet_Y  output  10 each  bullet top-left corner.
REQ-014 SHALL have port bullet_dir  output  3  direction latched at launch, same encoding as tank_dir.

Function
REQ-015 SHALL generate frame_tick as a registered pulse: frame_tick <= frame_clk & ~frame_clk_d, with frame_clk_d <= frame_clk; one Clk cycle wide per frame_clk rising edge.
REQ-016 SHALL latch fire_req <= 1 on any cycle with is_shooting=1; fire_req SHALL clear on every frame_tick cycle.
REQ-017 SHALL define fire = (fire_req | is_shooting) on the frame_tick cycle, so a pulse coincident with frame_tick counts.
REQ-018 SHALL implement states IDLE, FLYING, COOLDOWN; all state and position updates occur only on frame_tick cycles.
REQ-019 IDLE: on frame_tick with fire and tank_dir in {1,2,3,4} and spawn in-bounds, SHALL go FLYING, load bullet_X=tank_X+14, bullet_Y=tank_Y+14, bullet_dir=tank_dir, bullet_active=1.
REQ-020 Spawn is in-bounds iff tank_X+14 <= 640-SIZE and tank_Y+14 <= 480-SIZE (11-bit compare); otherwise the request is dropped and state stays IDLE.
REQ-021 Fire with invalid tank_dir SHALL be dropped; state stays IDLE.
REQ-022 FLYING, per frame_tick: up: if bullet_Y < STEP terminate else bullet_Y -= STEP; down: if bullet_Y+STEP > 480-SIZE terminate else bullet_Y += STEP; right: if bullet_X+STEP > 640-SIZE terminate else bullet_X += STEP; left: if bullet_X < STEP terminate else bullet_X -= STEP.
REQ-023 Terminate SHALL clear bullet_active, hold bullet_X/Y/dir at last values, load cooldown counter with COOLDOWN, go COOLDOWN, same cycle.
REQ-024 Fire requests in FLYING or COOLDOWN SHALL be ignored (single bullet in flight, no queueing).
REQ-025 COOLDOWN: each frame_tick decrements the counter; the tick on which the counter reads 1 SHALL go IDLE; fire on that same tick is ignored; next tick may launch.
REQ-026 Bullet motion SHALL be independent of later tank_X/Y/tank_dir changes.
REQ-027 is_bullet SHALL be combinational: bullet_active & bullet_X <= DrawX <= bullet_X+SIZE-1 & bullet_Y <= DrawY <= bullet_Y+SIZE-1, unsigned, no wrap.
REQ-028 All arithmetic SHALL be unsigned with 11-bit intermediates; no position ever wraps below 0 or above 639/479.

Reset
REQ-029 On Reset=1 at a Clk edge: state=IDLE, bullet_active=0, bullet_X=0, bullet_Y=0, bullet_dir=0, cooldown=0, fire_req=0, frame_clk_d=0, frame_tick=0.
REQ-030 Reset SHALL take priority over frame_tick and fire in the same cycle, including mid-flight and mid-cooldown.
REQ-031 is_bullet SHALL be 0 during and after reset until a launch.

Verification
REQ-032 tank (500,240), dir 1, is_shooting pulse -> next tick: active=1, bullet (514,254); after 3 more ticks bullet_Y=242, bullet_X=514.
REQ-033 dir 3, bullet_X=6 in flight -> tick: X=2; next tick: active=0, X held 2, state COOLDOWN; launch accepted only on the 17th tick after termination.
REQ-034 dir 2, tank_X=630 fire -> spawn 644 > 636, request dropped, active stays 0.
REQ-035 is_shooting held high every cycle while FLYING -> no relaunch, bullet position unaffected; tank moves -> bullet path unchanged.
REQ-036 Reset asserted mid-flight at bullet (514,100) -> next cycle active=0, X=Y=0, is_bullet=0; fire after reset launches normally.
REQ-037 Bullet at (514,254), active: DrawX/DrawY=(517,257) -> is_bullet=1; (518,257) -> 0; tank_dir=5 fire -> dropped.
